// File: rtl/fft_pkg.sv
// Shared FFT datapath types and helpers: complex sample type,
// frame-length helper and bit-reversal of frame indices.
package fft_pkg;

    localparam int N_DEF  = 3;
    localparam int DW_DEF = 16;

    typedef struct packed {
        logic signed [DW_DEF-1:0] re;
        logic signed [DW_DEF-1:0] im;
    } cplx_t;

    typedef enum logic {
        W_IDLE,
        W_FILL
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RUN
    } rd_state_t;

    function automatic int frame_len(input int n);
        return 1 << n;
    endfunction

    // Reverse the n least-significant bits of k.
    function automatic logic [31:0] bitrev(
        input logic [31:0] k,
        input int          n
    );
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                r[n-1-i] = k[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pingpong_ram.sv
// Two-bank frame buffer: one write port, one registered read port.
// Bank and address are concatenated into a single flat index.
module pingpong_ram #(
    parameter int AW = 3,
    parameter int WW = 32
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_wr_bank,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [WW-1:0] i_wr_data,
    input  logic          i_rd_bank,
    input  logic [AW-1:0] i_rd_addr,
    output logic [WW-1:0] o_rd_data
);

    localparam int DEPTH = 2 * (1 << AW);

    logic [WW-1:0] r_mem [DEPTH];
    logic [WW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        end
        r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bit_reverse_reorder.sv
// Buffers bit-reversed SDF FFT frames and re-emits them in natural
// order through a ping-pong buffer, one sample per clock.
module bit_reverse_reorder
    import fft_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] ip_re,
    input  logic signed [DW-1:0] ip_im,
    input  logic                 start_ip,
    output logic signed [DW-1:0] op_re,
    output logic signed [DW-1:0] op_im,
    output logic                 op_valid,
    output logic                 start_op,
    output logic                 restart_err
);

    localparam int          L    = frame_len(N);
    localparam logic [N-1:0] LAST = N'(L - 1);

    wr_state_t      r_wst;
    logic [N-1:0]   r_wr_cnt;
    logic           r_wr_bank;
    logic [1:0]     r_full;
    logic           r_restart_err;

    rd_state_t      r_rst;
    logic [N-1:0]   r_rd_cnt;
    logic           r_rd_bank;
    logic           r_p_valid;
    logic           r_p_start;

    logic signed [DW-1:0] r_op_re;
    logic signed [DW-1:0] r_op_im;
    logic                 r_op_valid;
    logic                 r_start_op;

    logic            w_we;
    logic [N-1:0]    w_wr_addr;
    logic [2*DW-1:0] w_wr_data;
    logic [2*DW-1:0] w_rd_data;
    logic            w_wr_done;
    logic            w_rd_done;
    logic            w_ovf;
    logic [1:0]      w_set;
    logic [1:0]      w_clr;
    logic [1:0]      w_full_nxt;

    // A start pulse always lands at index 0, aborting any partial frame.
    always_comb begin
        w_we      = start_ip || (r_wst == W_FILL);
        w_wr_addr = '0;
        if (!start_ip) begin
            w_wr_addr = N'(bitrev(32'(r_wr_cnt), N));
        end
        w_wr_data = {ip_re, ip_im};
        w_wr_done = (r_wst == W_FILL) && !start_ip
                    && (r_wr_cnt == LAST);
        w_rd_done = (r_rst == R_RUN) && (r_rd_cnt == LAST);
        w_ovf     = w_wr_done && (&r_full);
        w_set     = '0;
        w_clr     = '0;
        if (w_wr_done) begin
            w_set[r_wr_bank] = 1'b1;
        end
        if (w_rd_done) begin
            w_clr[r_rd_bank] = 1'b1;
        end
        w_full_nxt = (r_full & ~w_clr) | w_set;
    end

    pingpong_ram #(
        .AW (N),
        .WW (2 * DW)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_bank (r_wr_bank),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_bank (r_rd_bank),
        .i_rd_addr (r_rd_cnt),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wst         <= W_IDLE;
            r_wr_cnt      <= '0;
            r_wr_bank     <= 1'b0;
            r_restart_err <= 1'b0;
        end else begin
            r_restart_err <= ((r_wst == W_FILL) && start_ip)
                             || w_ovf;
            case (r_wst)
                W_IDLE: begin
                    if (start_ip) begin
                        r_wr_cnt <= N'(1);
                        r_wst    <= W_FILL;
                    end
                end
                W_FILL: begin
                    if (start_ip) begin
                        r_wr_cnt <= N'(1);
                    end else if (r_wr_cnt == LAST) begin
                        r_wr_cnt  <= '0;
                        r_wr_bank <= ~r_wr_bank;
                        r_wst     <= W_IDLE;
                    end else begin
                        r_wr_cnt <= r_wr_cnt + N'(1);
                    end
                end
                default: r_wst <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    // Read side looks at next-state full flags so a bank completing
    // on this edge is picked up without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst     <= R_IDLE;
            r_rd_cnt  <= '0;
            r_rd_bank <= 1'b0;
            r_p_valid <= 1'b0;
            r_p_start <= 1'b0;
        end else begin
            r_p_valid <= (r_rst == R_RUN);
            r_p_start <= (r_rst == R_RUN) && (r_rd_cnt == '0);
            case (r_rst)
                R_IDLE: begin
                    if (|w_full_nxt) begin
                        r_rd_bank <= ~w_full_nxt[0];
                        r_rd_cnt  <= '0;
                        r_rst     <= R_RUN;
                    end
                end
                R_RUN: begin
                    if (r_rd_cnt == LAST) begin
                        r_rd_cnt <= '0;
                        if (w_full_nxt[~r_rd_bank]) begin
                            r_rd_bank <= ~r_rd_bank;
                        end else begin
                            r_rst <= R_IDLE;
                        end
                    end else begin
                        r_rd_cnt <= r_rd_cnt + N'(1);
                    end
                end
                default: r_rst <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_re    <= '0;
            r_op_im    <= '0;
            r_op_valid <= 1'b0;
            r_start_op <= 1'b0;
        end else begin
            r_op_valid <= r_p_valid;
            r_start_op <= r_p_start;
            if (r_p_valid) begin
                r_op_re <= w_rd_data[2*DW-1:DW];
                r_op_im <= w_rd_data[DW-1:0];
            end
        end
    end

    assign op_re       = r_op_re;
    assign op_im       = r_op_im;
    assign op_valid    = r_op_valid;
    assign start_op    = r_start_op;
    assign restart_err = r_restart_err;

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Directed self-checking bench for bit_reverse_reorder (N=3, DW=16).
// Outputs are logged each falling edge and checked against tables.
module tb_bit_reverse_reorder;

    localparam int N  = 3;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] ip_re = '0;
    logic signed [DW-1:0] ip_im = '0;
    logic                 start_ip = 1'b0;
    logic signed [DW-1:0] op_re;
    logic signed [DW-1:0] op_im;
    logic                 op_valid;
    logic                 start_op;
    logic                 restart_err;

    bit_reverse_reorder #(
        .N  (N),
        .DW (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ip_re       (ip_re),
        .ip_im       (ip_im),
        .start_ip    (start_ip),
        .op_re       (op_re),
        .op_im       (op_im),
        .op_valid    (op_valid),
        .start_op    (start_op),
        .restart_err (restart_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int re;
        int im;
        bit st;
    } ent_t;

    int   cyc = 0;
    ent_t q[$];
    int   n_err_pulse = 0;
    int   n_stray = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (op_valid) begin
            q.push_back('{cyc, int'(op_re), int'(op_im), start_op});
        end
        if (restart_err) n_err_pulse++;
        if (start_op && !op_valid) n_stray++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit s, input int re, input int im);
        start_ip = s;
        ip_re    = DW'(re);
        ip_im    = DW'(im);
        @(posedge clk);
        @(negedge clk);
        #1;
        start_ip = 1'b0;
        ip_re    = '0;
        ip_im    = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0);
    endtask

    task automatic frame(input int off, output int t);
        t = 0;
        for (int k = 0; k < 8; k++) begin
            step(k == 0, off + br[k] * 100, -(off + br[k] * 100));
            if (k == 0) t = cyc;
        end
    endtask

    task automatic burst(input string tag, input int b,
                         input int t0, input int off);
        ent_t e;
        for (int j = 0; j < 8; j++) begin
            if (b + j >= q.size()) begin
                chk({tag, "_missing"}, q.size(), b + j + 1);
            end else begin
                e = q[b + j];
                chk({tag, "_re"}, e.re, off + j * 100);
                chk({tag, "_im"}, e.im, -(off + j * 100));
                chk({tag, "_cyc"}, e.c, t0 + j);
                chk({tag, "_st"}, int'(e.st), int'(j == 0));
            end
        end
    endtask

    initial begin
        int t;
        int t2;
        int t3;
        int e0;

        rst = 1'b1;
        idle(3);
        chk("rst_re", int'(op_re), 0);
        chk("rst_im", int'(op_im), 0);
        chk("rst_valid", int'(op_valid), 0);
        chk("rst_start", int'(start_op), 0);
        chk("rst_err", int'(restart_err), 0);
        rst = 1'b0;
        idle(2);

        q.delete();
        frame(0, t);
        idle(12);
        chk("single_n", q.size(), 8);
        burst("single", 0, t + 9, 0);

        q.delete();
        frame(1000, t);
        frame(2000, t2);
        frame(3000, t3);
        idle(14);
        chk("b2b_n", q.size(), 24);
        burst("b2b_f1", 0, t + 9, 1000);
        burst("b2b_f2", 8, t + 17, 2000);
        burst("b2b_f3", 16, t + 25, 3000);

        q.delete();
        e0 = n_err_pulse;
        for (int k = 0; k < 5; k++) begin
            step(k == 0, 9000 + br[k], -(9000 + br[k]));
        end
        frame(4000, t);
        idle(12);
        chk("restart_pulses", n_err_pulse - e0, 1);
        chk("restart_n", q.size(), 8);
        burst("restart", 0, t + 9, 4000);

        q.delete();
        frame(5000, t);
        idle(5);
        rst = 1'b1;
        step(1'b0, 0, 0);
        rst = 1'b0;
        chk("midrst_re", int'(op_re), 0);
        chk("midrst_im", int'(op_im), 0);
        chk("midrst_valid", int'(op_valid), 0);
        chk("midrst_start", int'(start_op), 0);
        chk("midrst_n", q.size(), 4);
        idle(2);
        q.delete();
        frame(6000, t);
        idle(12);
        chk("postrst_n", q.size(), 8);
        burst("postrst", 0, t + 9, 6000);

        q.delete();
        frame(7000, t);
        idle(5);
        frame(8000, t2);
        idle(12);
        chk("gap_n", q.size(), 16);
        burst("gap_f1", 0, t + 9, 7000);
        burst("gap_f2", 8, t2 + 9, 8000);
        chk("gap_start_delta", t2 - t, 13);

        chk("stray_start", n_stray, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_reverse_reorder.md
Name: bit_reverse_reorder

Overview:
- Output reorder stage placed directly downstream of the last radix-2 SDF butterfly stage.
- The last SDF stage emits each 2^N-point frame in bit-reversed index order. This block buffers the frame and re-emits it in natural order, with a frame-start pulse for the next consumer.
- It uses ping-pong double buffering, so back-to-back frames stream continuously at one sample per clock.
- Data is signed fixed-point complex (real/imag pair) and passes through unmodified.

Parameters:
- N, 3, log2 of FFT size; frame length L = 2^N.
- DW, 16, bit width of each real/imag component (signed two's complement).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ip_re  input  DW  real part of incoming sample (bit-reversed order).
- ip_im  input  DW  imaginary part of incoming sample.
- start_ip  input  1  one-cycle pulse; marks the first sample of a frame, valid on the same edge.
- op_re  output  DW  real part of outgoing sample (natural order), registered.
- op_im  output  DW  imaginary part of outgoing sample, registered.
- op_valid  output  1  high while op_re/op_im carry frame samples.
- start_op  output  1  one-cycle pulse coincident with output sample index 0.
- restart_err  output  1  one-cycle pulse when start_ip aborts a partially written frame.

Behaviour:
- Reset (rst high at edge):
  - op_re=0, op_im=0, op_valid=0, start_op=0, restart_err=0.
  - Write FSM=W_IDLE, read FSM=R_IDLE, wr_cnt=0, rd_cnt=0, wr_bank=0, both bank-full flags cleared.
  - Memory contents are don't-care.
  - Reset mid-frame or mid-read abandons all data; no output is produced for partial frames.
- Write FSM {W_IDLE, W_FILL}:
  - W_IDLE: on start_ip=1, write ip to bank wr_bank at address bitrev(0)=0, wr_cnt<=1, go to W_FILL. Otherwise hold.
  - W_FILL, start_ip=0: write ip at address bitrev(wr_cnt), wr_cnt<=wr_cnt+1.
    - When wr_cnt==L-1 (last sample): set full[wr_bank], toggle wr_bank, wr_cnt<=0, go to W_IDLE.
  - W_FILL, start_ip=1: partial frame discarded; restart_err=1 next cycle; sample treated as index 0 of a new frame in the same bank (wr_cnt<=1, stay W_FILL).
- bitrev(k): reverse the N LSBs of k. For N=3 the order is 0,4,2,6,1,5,3,7.
- Read FSM {R_IDLE, R_RUN}:
  - R_IDLE: if any bank is full, set rd_bank to that bank, rd_cnt<=0, go to R_RUN. The full flag may be set on this same edge.
  - R_RUN: each cycle, register mem[rd_bank][rd_cnt] onto op_re/op_im, op_valid=1, and start_op=1 iff rd_cnt==0.
  - At rd_cnt==L-1: clear full[rd_bank]. If the other bank is full (including set on this edge), continue seamlessly with rd_cnt<=0 on the other bank. Otherwise go to R_IDLE.
  - In R_IDLE, op_valid=0, start_op=0, and op holds its last value.
- Latency:
  - start_ip sampled at edge t0 with sample 0; last input sample at t0+L-1.
  - The first output appears on edge t0+L+1, i.e. registered: start_op and op_valid are high during the cycle after edge t0+L+1.
  - Fixed latency of L+1 clocks from start_ip to start_op.
- Rate/overflow: input rate never exceeds one sample/clock, so at most one bank is being read while the other fills. Two banks are never full while a third frame completes.
  - A frame completing while both flags are set is a protocol violation. The newest frame overwrites the bank not being read, and restart_err pulses.
- Read/write collision: the write bank and read bank are always different banks, so no read-during-write hazard exists within a bank.
- Gaps between frames (start_ip absent) produce op_valid=0 gaps. No spurious start_op.

Decomposition:
- Shared package fft_pkg holds:
  - the complex fixed-point struct type (re, im of DW bits);
  - the bitrev function parameterised by N;
  - the frame-length constant helper L=2^N.
- One natural sub-module: pingpong_ram, two L×(2·DW) banks with one write port (bank, addr, data) and one registered read port (bank, addr).
- The two FSMs and the full flags live in bit_reverse_reorder.

Test Plan:
- Single frame (N=3, DW=16): pulse start_ip, feed re=bitrev(k)·100 for k=0..7, i.e. re=0,400,200,600,100,500,300,700, im=-re. Output re=0,100,...,700 with im negated; start_op 9 cycles after start_ip; op_valid high exactly 8 cycles.
- Back-to-back frames: three frames with start_ip every 8 cycles (frames offset by +1000). Output is 24 contiguous valid cycles in natural order, with start_op pulses 8 apart and no gaps.
- Mid-frame restart: start_ip, 5 samples, start_ip again, then a full frame. restart_err pulses once; only the second frame is emitted, with start_op 9 cycles after the second start_ip.
- Reset mid-read: assert rst during output sample 3 of a frame. On the next cycle all outputs are 0 and op_valid=0; a new frame afterwards emits correctly with latency 9.
- Gap between frames: frame, 5 idle cycles, frame. Two separate 8-sample bursts, op_valid low for 5 cycles between them, and start_op pulses only at sample 0 of each burst.
